// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry,
// FSM state encoding and a small address-check helper.
package icache_pkg;

    localparam int IDX_BITS_DEF   = 3;
    localparam int OFF_BITS       = 2;
    localparam int WORDS_PER_LINE = 4;
    localparam int TAG_BITS       = 16 - 3 - IDX_BITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A fetch is misaligned when it asks for an odd byte address.
    function automatic logic misaligned(input logic req, input logic [15:0] addr);
        return req & addr[0];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Backing-memory read bus: one request outstanding, completion signalled by
// a single-cycle mem_valid pulse carrying the read data.
interface icache_if;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_valid
    );

endinterface

// File: rtl/icache_line_array.sv
// Line storage for the instruction cache: per-line valid bit, tag and four
// 16-bit words. Combinational read port, one word-write port and a
// tag-write/valid-set port sharing the write index.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int TAG_W    = 16 - 3 - IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_clr,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [OFF_BITS-1:0] rd_off,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [15:0]         rd_word,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [OFF_BITS-1:0] wr_off,
    input  logic [15:0]         wr_data,
    input  logic                set_en,
    input  logic [TAG_W-1:0]    set_tag
);

    localparam int LINES = 1 << IDX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES][WORDS_PER_LINE];

    // Valid bits: reset and flush clear every line; flush beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush_clr) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[wr_idx] <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Tag and data payload: only meaningful behind a set valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_q[wr_idx] <= set_tag;
        end
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
    end

    // Combinational lookup for the hit path.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_word  = data_q[rd_idx][rd_off];
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller. Hits are served in
// the request cycle; a miss stalls fetch while a 4-word line is refilled in
// order from backing memory, one word outstanding at a time.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] pc_addr,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        err,
    icache_if.master    mem
);

    localparam int TAG_W = 16 - 3 - IDX_BITS;

    state_e                state_q;
    logic [OFF_BITS-1:0]   cnt_q;
    logic [TAG_W-1:0]      fill_tag_q;
    logic [IDX_BITS-1:0]   fill_idx_q;
    logic                  flush_pend_q;

    logic [TAG_W-1:0]      tag_s;
    logic [IDX_BITS-1:0]   idx_s;
    logic [OFF_BITS-1:0]   off_s;
    logic                  rd_valid_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [15:0]           rd_word_s;
    logic                  hit_s;
    logic                  err_s;
    logic                  miss_s;
    logic                  wr_en_s;
    logic                  set_en_s;

    // Address split and hit/miss classification of the current fetch.
    always_comb begin
        tag_s  = pc_addr[15:3+IDX_BITS];
        idx_s  = pc_addr[2+IDX_BITS:3];
        off_s  = pc_addr[2:1];
        hit_s  = rd_valid_s & (rd_tag_s == tag_s);
        err_s  = misaligned(fetch_req, pc_addr);
        miss_s = fetch_req & ~pc_addr[0] & ~hit_s;
    end

    // Refill write controls; a flush seen during the fill keeps the line invalid.
    always_comb begin
        wr_en_s  = (state_q == ST_FILL) & mem.mem_valid;
        set_en_s = wr_en_s & (cnt_q == 2'd3) & ~flush_pend_q & ~flush;
    end

    icache_line_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .flush_clr (flush),
        .rd_idx    (idx_s),
        .rd_off    (off_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_word   (rd_word_s),
        .wr_en     (wr_en_s),
        .wr_idx    (fill_idx_q),
        .wr_off    (cnt_q),
        .wr_data   (mem.mem_rdata),
        .set_en    (set_en_s),
        .set_tag   (fill_tag_q)
    );

    // Controller FSM: capture the miss, count refill words, hold one DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_s) begin
                        fill_tag_q   <= tag_s;
                        fill_idx_q   <= idx_s;
                        cnt_q        <= 2'd0;
                        flush_pend_q <= flush;
                        state_q      <= ST_FILL;
                    end else begin
                        flush_pend_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem.mem_valid) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    flush_pend_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    cnt_q        <= 2'd0;
                    flush_pend_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch-side outputs: same-cycle hit data, stall on miss and while busy.
    always_comb begin
        instr       = 16'h0000;
        instr_valid = 1'b0;
        stall       = 1'b0;
        err         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (err_s) begin
                    err = 1'b1;
                end else if (fetch_req & hit_s) begin
                    instr       = rd_word_s;
                    instr_valid = 1'b1;
                end else if (fetch_req) begin
                    stall = 1'b1;
                end else begin
                    stall = 1'b0;
                end
            end
            ST_FILL, ST_DONE: begin
                stall = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Memory request is driven purely from fill registers, so the address only
    // moves on the edge that consumed mem_valid.
    always_comb begin
        if (state_q == ST_FILL) begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = {fill_tag_q, fill_idx_q, cnt_q, 1'b0};
        end else begin
            mem.mem_req  = 1'b0;
            mem.mem_addr = 16'h0000;
        end
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache controller sitting directly upstream of the instruction fetch stage.
- Serves 16-bit instructions to fetch on a hit in the same cycle.
- On a miss, asserts stall and refills a 4-word line from a multicycle backing memory using a req/valid handshake, one word outstanding at a time.
- Replaces the single-cycle instruction memory ahead of the pipelined/stalling processor.

Parameters:
- IDX_BITS, 3, index width; line count = 2^IDX_BITS (default 8 lines).
- WORDS_PER_LINE: fixed at 4, not a parameter. Offset is addr[2:1]; byte bit addr[0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block
- fetch_req  in  1  fetch wants instruction at pc_addr this cycle
- pc_addr  in  16  byte address of requested instruction
- flush  in  1  invalidate all lines (one-cycle pulse)
- instr  out  16  instruction word; valid only when instr_valid=1
- instr_valid  out  1  instr holds data for pc_addr this cycle
- stall  out  1  fetch must hold pc_addr; controller busy
- mem_req  out  1  read request to backing memory
- mem_addr  out  16  word-aligned byte address of the request
- mem_rdata  in  16  read data from backing memory
- mem_valid  in  1  one-cycle pulse: mem_rdata valid, current request complete
- err  out  1  misaligned fetch (fetch_req & pc_addr[0])

Behaviour:
- Address split:
  - tag = addr[15:3+IDX_BITS]
  - idx = addr[2+IDX_BITS:3]
  - off = addr[2:1]
- Storage per line: valid bit, tag, 4x16 data.
- Reset (rst==0): all valid bits cleared, FSM to IDLE, word counter 0.
  - Outputs at reset: instr=0, instr_valid=0, stall=0, mem_req=0, mem_addr=0, err=0.
  - Reset mid-FILL aborts the fill immediately. A later mem_valid in IDLE is ignored.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - fetch_req & pc_addr[0]: err=1, instr_valid=0, stall=0, no fill. Stay IDLE.
  - fetch_req & hit (valid[idx] & tag match): instr=data[idx][off] combinationally, instr_valid=1, stall=0. Hit latency is 0 cycles.
  - fetch_req & miss: stall=1 combinationally. Capture fill tag/idx into registers, cnt=0, go to FILL.
  - No fetch_req: all outputs 0 except instr, which is don't-care but driven 0.
- FILL:
  - stall=1, mem_req=1, mem_addr={fill_tag, fill_idx, cnt, 1'b0}.
  - On mem_valid: data[fill_idx][cnt] <= mem_rdata, cnt <= cnt+1.
    - If cnt==3: write tag[fill_idx] and set valid[fill_idx] unless flush_pend. Go to DONE.
  - mem_addr changes only the cycle after mem_valid. mem_req stays high across words.
  - Words are fetched in order 0..3; there is no critical-word-first.
- DONE: stall=1, mem_req=0, clear flush_pend, go to IDLE. The next cycle re-evaluates pc_addr, normally as a hit.
- Miss latency: 1 (detect) + sum of 4 memory latencies + 1 (DONE). Then the hit is served in the following cycle.
- flush:
  - In IDLE or DONE: clears all valid bits at the edge. Same-cycle lookup still uses the pre-flush valid bits.
  - In FILL: clears all valid bits and sets flush_pend. The fill completes and writes data, but the line is not marked valid.
- pc_addr or fetch_req changing during FILL/DONE is ignored; the fill finishes for the captured address.
- flush and miss detected in the same IDLE cycle: the fill starts and flush_pend is set.
- Memory side never sees mem_req=1 outside FILL.

Decomposition:
- Shared package icache_pkg: IDX_BITS default, OFF_BITS=2, TAG_BITS=16-3-IDX_BITS, FSM state encodings (IDLE=2'b00, FILL=2'b01, DONE=2'b10).
- One sub-module icache_line_array:
  - Holds valid/tag/data registers.
  - Combinational read port (idx, off -> valid, tag, word).
  - One word-write port plus tag/valid-set port.
  - Synchronous active-low clear and flush-clear input.
- Controller FSM, counter and flush_pend live in icache_ctrl.

Test Plan:
- Cold miss, memory latency 2:
  - Stimulus: reset, then fetch_req=1, pc_addr=0x0010.
  - Required: stall=1 for 1+8+1=10 cycles; mem_addr sequence 0x0010, 0x0012, 0x0014, 0x0016; next cycle instr_valid=1 with word 0.
- Spatial hits:
  - Stimulus: after the cold-miss scenario, pc_addr=0x0012, 0x0014, 0x0016 on consecutive cycles.
  - Required: instr_valid=1 and stall=0 on each, matching the preloaded memory words; mem_req stays 0.
- Conflict (IDX_BITS=3):
  - Stimulus: fetch 0x0010, then 0x0050 (same idx, different tag), then 0x0010 again.
  - Required: three fills; the last returns the original word.
- Flush during fill:
  - Stimulus: pulse flush in the 2nd cycle of a FILL for 0x0100.
  - Required: fill completes (4 mem_valid), DONE, then the same pc misses again and refills.
- Misaligned fetch:
  - Stimulus: pc_addr=0x0021 with fetch_req=1.
  - Required: err=1, stall=0, instr_valid=0, mem_req=0.
- Reset mid-fill:
  - Stimulus: drive rst=0 after the 2nd mem_valid, deliver a stray mem_valid after release.
  - Required: mem_req=0, all outputs at reset values, stray pulse ignored; re-fetch 0x0010 misses.
